// File: rtl/multdiv.sv
// Multi-cycle 32-bit signed multiply (Booth) / divide (restoring) unit.
// Define MULTDIV_RADIX4_EN to use radix-4 Booth recoding (16-cycle multiply).
module multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

`ifdef MULTDIV_RADIX4_EN
  localparam int MUL_STEPS = 16;
`else
  localparam int MUL_STEPS = 32;
`endif
  localparam int DIV_STEPS = 32;

  state_t      state_q, state_d;
  logic        start;
  logic [5:0]  cnt_q;
  logic [31:0] opa_q, opb_q;

  // Multiply: 34-bit signed upper half absorbs +/-2A without overflow
  logic [33:0] hi_q;
  logic [31:0] lo_q;
  logic        qm1_q;
  logic [33:0] a_ext, a2_ext, mul_sum, hi_n;
  logic [31:0] lo_n;
  logic        qm1_n;
  logic [63:0] mul_prod;
  logic        mul_exc;

  // Divide: remainder/quotient pair on operand magnitudes
  logic [31:0] rem_q, quo_q;
  logic [31:0] amag_in, bmag;
  logic [32:0] sh_hi;
  logic        div_ge;
  logic [31:0] rem_n, quo_n, quo_fix;
  logic        div_ovf;

  logic        mul_last, div_zero, div_last;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign mul_last = (cnt_q == 6'(MUL_STEPS - 1));
  assign div_zero = (opb_q == 32'd0);
  assign div_last = (cnt_q == 6'(DIV_STEPS));

  // ---------------- Booth step ----------------
  assign a_ext  = {{2{opa_q[31]}}, opa_q};
  assign a2_ext = {opa_q[31], opa_q, 1'b0};

`ifdef MULTDIV_RADIX4_EN
  always_comb begin
    case ({lo_q[1:0], qm1_q})
      3'b001, 3'b010: mul_sum = hi_q + a_ext;
      3'b011:         mul_sum = hi_q + a2_ext;
      3'b100:         mul_sum = hi_q - a2_ext;
      3'b101, 3'b110: mul_sum = hi_q - a_ext;
      default:        mul_sum = hi_q;
    endcase
    {hi_n, lo_n, qm1_n} = 67'($signed({mul_sum, lo_q, qm1_q}) >>> 2);
  end
`else
  always_comb begin
    case ({lo_q[0], qm1_q})
      2'b01:   mul_sum = hi_q + a_ext;
      2'b10:   mul_sum = hi_q - a_ext;
      default: mul_sum = hi_q;
    endcase
    {hi_n, lo_n, qm1_n} = 67'($signed({mul_sum, lo_q, qm1_q}) >>> 1);
  end
`endif

  assign mul_prod = {hi_n[31:0], lo_n};
  assign mul_exc  = !((&mul_prod[63:31]) || !(|mul_prod[63:31]));

  // ---------------- Restoring divide step ----------------
  assign amag_in = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign bmag    = opb_q[31] ? (32'd0 - opb_q) : opb_q;
  assign sh_hi   = {rem_q, quo_q[31]};
  assign div_ge  = (sh_hi >= {1'b0, bmag});
  // When div_ge holds the true difference is below 2^31, so 32 bits suffice
  assign rem_n   = div_ge ? (sh_hi[31:0] - bmag) : sh_hi[31:0];
  assign quo_n   = {quo_q[30:0], div_ge};
  assign quo_fix = (opa_q[31] ^ opb_q[31]) ? (32'd0 - quo_q) : quo_q;
  assign div_ovf = (opa_q == 32'h8000_0000) && (opb_q == 32'hFFFF_FFFF);

  // ---------------- FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ctrl_MULT ? MUL : DIV;
    end else begin
      case (state_q)
        MUL:     if (mul_last) state_d = DONE;
        DIV:     if (div_zero || div_last) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- Datapath and outputs ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      opa_q          <= '0;
      opb_q          <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      qm1_q          <= 1'b0;
      rem_q          <= '0;
      quo_q          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // A start anywhere aborts whatever is in flight
        cnt_q <= '0;
        opa_q <= data_operandA;
        opb_q <= data_operandB;
        hi_q  <= '0;
        lo_q  <= data_operandB;
        qm1_q <= 1'b0;
        rem_q <= '0;
        quo_q <= amag_in;
      end else begin
        case (state_q)
          MUL: begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            qm1_q <= qm1_n;
            cnt_q <= cnt_q + 6'd1;
            if (mul_last) begin
              data_result    <= mul_prod[31:0];
              data_exception <= mul_exc;
              data_resultRDY <= 1'b1;
            end
          end
          DIV: begin
            if (div_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
            end else if (div_last) begin
              data_result    <= quo_fix;
              data_exception <= div_ovf;
              data_resultRDY <= 1'b1;
            end else begin
              rem_q <= rem_n;
              quo_q <= quo_n;
              cnt_q <= cnt_q + 6'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Directed self-checking bench for multdiv: latency, results, exceptions, restart, reset.
module tb_multdiv;

`ifdef MULTDIV_RADIX4_EN
  localparam int MUL_LAT = 16;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 33;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int checks = 0;
  int errors = 0;

  multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Issue one op (start edge = E0), then wait at most 60 edges for RDY.
  task automatic run_op(input bit mult, input logic [31:0] a, input logic [31:0] b,
                        input bit chk_pulse, output int lat, output logic [31:0] res,
                        output logic exc, output logic rdy_next, output logic [31:0] res_e0);
    @(negedge clock);
    ctrl_MULT = mult; ctrl_DIV = !mult; data_operandA = a; data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'hDEAD_BEEF; data_operandB = 32'h0BAD_F00D;
    res_e0 = data_result;
    lat = -1; res = 32'hx; exc = 1'bx; rdy_next = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        lat = k; res = data_result; exc = data_exception;
        break;
      end
    end
    if (chk_pulse && lat > 0) begin
      @(posedge clock); #1;
      rdy_next = data_resultRDY;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (data_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc: got %b expected 0", data_exception); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_mult();
    logic [31:0] va[3] = '{32'd7, 32'h0001_0000, 32'h8000_0000};
    logic [31:0] vb[3] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1};
    logic [31:0] vr[3] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000};
    logic        ve[3] = '{1'b0, 1'b1, 1'b0};
    int lat; logic [31:0] res, r0; logic exc, rn;
    for (int i = 0; i < 3; i++) begin
      run_op(1'b1, va[i], vb[i], 1'b1, lat, res, exc, rn, r0);
      checks++; if (res !== vr[i]) begin errors++; $display("FAIL mult%0d_result: got %h expected %h", i, res, vr[i]); end
      checks++; if (exc !== ve[i]) begin errors++; $display("FAIL mult%0d_exc: got %b expected %b", i, exc, ve[i]); end
      checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mult%0d_latency: got %0d expected %0d", i, lat, MUL_LAT); end
      checks++; if (rn !== 1'b0) begin errors++; $display("FAIL mult%0d_rdy_width: got %b expected 0", i, rn); end
    end
  endtask

  task automatic test_div();
    logic [31:0] va[5] = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000, 32'd100};
    logic [31:0] vb[5] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    logic [31:0] vr[5] = '{32'hFFFF_FFFD, 32'd14, 32'd0, 32'h8000_0000, 32'hFFFF_FFF2};
    logic        ve[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int          vl[5] = '{DIV_LAT, DIV_LAT, 1, DIV_LAT, DIV_LAT};
    int lat; logic [31:0] res, r0; logic exc, rn;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, va[i], vb[i], 1'b1, lat, res, exc, rn, r0);
      checks++; if (res !== vr[i]) begin errors++; $display("FAIL div%0d_result: got %h expected %h", i, res, vr[i]); end
      checks++; if (exc !== ve[i]) begin errors++; $display("FAIL div%0d_exc: got %b expected %b", i, exc, ve[i]); end
      checks++; if (lat !== vl[i]) begin errors++; $display("FAIL div%0d_latency: got %0d expected %0d", i, lat, vl[i]); end
      checks++; if (rn !== 1'b0) begin errors++; $display("FAIL div%0d_rdy_width: got %b expected 0", i, rn); end
    end
  endtask

  task automatic test_restart();
    bit early = 1'b0;
    int lat = -1;
    logic [31:0] res = 32'hx;
    logic exc = 1'bx;
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd4;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) early = 1'b1;
    end
    @(negedge clock);
    ctrl_DIV = 1'b1; data_operandA = 32'd20; data_operandB = 32'd5;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0; data_operandA = 32'h1234_5678; data_operandB = 32'd0;
    for (int e = 11; e <= 60; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin lat = e; res = data_result; exc = data_exception; break; end
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL restart_early_rdy: got %b expected 0", early); end
    checks++; if (lat !== 43) begin errors++; $display("FAIL restart_rdy_edge: got E%0d expected E43", lat); end
    checks++; if (res !== 32'd4) begin errors++; $display("FAIL restart_result: got %h expected 4", res); end
    checks++; if (exc !== 1'b0) begin errors++; $display("FAIL restart_exc: got %b expected 0", exc); end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int lat; logic [31:0] res, r0; logic exc, rn;
    @(negedge clock);
    ctrl_MULT = 1'b1; data_operandA = 32'd6; data_operandB = 32'd7;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    for (int e = 1; e <= 5; e++) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if (data_result !== 32'd0) begin errors++; $display("FAIL midreset_result: got %h expected 0", data_result); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL midreset_exc: got %b expected 0", data_exception); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL midreset_rdy: got %b expected 0", data_resultRDY); end
    @(posedge clock);
    @(negedge clock); reset = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_stray_rdy: got %b expected 0", seen); end
    run_op(1'b1, 32'd2, 32'd2, 1'b0, lat, res, exc, rn, r0);
    checks++; if (res !== 32'd4) begin errors++; $display("FAIL midreset_fresh_result: got %h expected 4", res); end
    checks++; if (lat !== MUL_LAT) begin errors++; $display("FAIL midreset_fresh_latency: got %0d expected %0d", lat, MUL_LAT); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res, r0; logic exc, rn;
    run_op(1'b1, 32'd5, 32'd6, 1'b0, lat, res, exc, rn, r0);
    checks++; if (res !== 32'd30) begin errors++; $display("FAIL b2b_mult_result: got %h expected 1e", res); end
    // Start the divide on the edge that ends the RDY pulse
    run_op(1'b0, 32'd100, 32'd7, 1'b1, lat, res, exc, rn, r0);
    checks++; if (r0 !== 32'd30) begin errors++; $display("FAIL b2b_result_hold: got %h expected 1e", r0); end
    checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL b2b_div_latency: got %0d expected %0d", lat, DIV_LAT); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL b2b_div_result: got %h expected e", res); end
    checks++; if (exc !== 1'b0) begin errors++; $display("FAIL b2b_div_exc: got %b expected 0", exc); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
